// File: rtl/lut4_cfg_loader_if.sv
// Serial truth-table stream into the loader and the committed LUT4 configuration bus out of it.
// master = configuration source / LUT bank side, slave = lut4_cfg_loader.
interface lut4_cfg_loader_if #(
    parameter int NUM_LUTS = 4,
    parameter int LUT_BITS = 16
);
    localparam int W = NUM_LUTS * LUT_BITS;

    logic         cfg_start;
    logic         cfg_valid;
    logic         cfg_data;
    logic         cfg_ready;
    logic         cfg_busy;
    logic         cfg_done;
    logic         cfg_err;
    logic [W-1:0] lut_cfg;

    modport master (
        output cfg_start, cfg_valid, cfg_data,
        input  cfg_ready, cfg_busy, cfg_done, cfg_err, lut_cfg
    );

    modport slave (
        input  cfg_start, cfg_valid, cfg_data,
        output cfg_ready, cfg_busy, cfg_done, cfg_err, lut_cfg
    );
endinterface

// File: rtl/lut4_cfg_loader.sv
// Bit-serial LUT4 config loader: shadow-assembles an MSB-first frame, commits atomically to lut_cfg (parity: LUT4_CFG_PARITY_EN).
// Latency: lut_cfg and cfg_done change together one cycle after the last frame bit (data bit, or parity bit if enabled).
// Backpressure: cfg_ready high only while bits are accepted; bits offered otherwise are dropped, cfg_valid gaps are free.
module lut4_cfg_loader #(
    parameter int NUM_LUTS = 4,
    parameter int LUT_BITS = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    lut4_cfg_loader_if.slave bus
);
    localparam int W     = NUM_LUTS * LUT_BITS;
    localparam int CNT_W = $clog2(W + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
`ifdef LUT4_CFG_PARITY_EN
        ST_PARITY,
`endif
        ST_COMMIT
    } state_t;

    state_t           r_state;
    logic [W-1:0]     r_shadow;
    logic [W-1:0]     r_lut;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ready;
    logic             r_busy;
    logic             r_done;
`ifdef LUT4_CFG_PARITY_EN
    logic             r_par;
    logic             r_err;
`endif

    logic             w_restart;
    logic             w_take;
    logic             w_last;
    logic [W-1:0]     w_shadow_nxt;

    // A start pulse during COMMIT is dropped so the commit always completes.
    assign w_restart    = bus.cfg_start && (r_state != ST_COMMIT);
    assign w_take       = !bus.cfg_start && bus.cfg_valid && (r_state == ST_SHIFT);
    assign w_last       = (r_cnt == CNT_W'(W - 1));
    assign w_shadow_nxt = {r_shadow[W-2:0], bus.cfg_data};

    always_ff @(posedge i_clk) begin
        if (w_take) begin
            r_shadow <= w_shadow_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_lut   <= '0;
            r_cnt   <= '0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef LUT4_CFG_PARITY_EN
            r_par   <= 1'b0;
            r_err   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            if (w_restart) begin
                r_state <= ST_SHIFT;
                r_cnt   <= '0;
                r_ready <= 1'b1;
                r_busy  <= 1'b1;
`ifdef LUT4_CFG_PARITY_EN
                r_par   <= 1'b0;
                r_err   <= 1'b0;
`endif
            end else begin
                case (r_state)
                    ST_SHIFT: begin
                        if (bus.cfg_valid) begin
                            r_cnt <= r_cnt + 1'b1;
`ifdef LUT4_CFG_PARITY_EN
                            r_par <= r_par ^ bus.cfg_data;
                            if (w_last) begin
                                r_state <= ST_PARITY;
                            end
`else
                            // Last bit goes straight to lut_cfg so commit lands on the same edge as cfg_done.
                            if (w_last) begin
                                r_state <= ST_COMMIT;
                                r_lut   <= w_shadow_nxt;
                                r_done  <= 1'b1;
                                r_ready <= 1'b0;
                            end
`endif
                        end
                    end
`ifdef LUT4_CFG_PARITY_EN
                    ST_PARITY: begin
                        if (bus.cfg_valid) begin
                            r_ready <= 1'b0;
                            if (r_par == bus.cfg_data) begin
                                r_state <= ST_COMMIT;
                                r_lut   <= r_shadow;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= ST_IDLE;
                                r_busy  <= 1'b0;
                                r_err   <= 1'b1;
                            end
                        end
                    end
`endif
                    ST_COMMIT: begin
                        r_state <= ST_IDLE;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.cfg_ready = r_ready;
    assign bus.cfg_busy  = r_busy;
    assign bus.cfg_done  = r_done;
    assign bus.lut_cfg   = r_lut;
`ifdef LUT4_CFG_PARITY_EN
    assign bus.cfg_err   = r_err;
`else
    assign bus.cfg_err   = 1'b0;
`endif

endmodule

// File: tb/tb_lut4_cfg_loader.sv
// Self-checking bench for lut4_cfg_loader: directed frames plus randomized frames/gaps/aborts against a bit-queue model.
module tb_lut4_cfg_loader;
    localparam int NUM_LUTS = 4;
    localparam int LUT_BITS = 16;
    localparam int W        = NUM_LUTS * LUT_BITS;
`ifdef LUT4_CFG_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lut4_cfg_loader_if #(.NUM_LUTS(NUM_LUTS), .LUT_BITS(LUT_BITS)) bus ();

    lut4_cfg_loader #(.NUM_LUTS(NUM_LUTS), .LUT_BITS(LUT_BITS)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a frame is just the list of bits accepted since the last start.
    bit          m_active;
    bit          m_commit;
    bit          m_err;
    logic [63:0] m_lut;
    bit          m_bits[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic s, input logic v, input logic d);
        int          p;
        logic [63:0] f;
        if (r) begin
            m_active = 0; m_commit = 0; m_err = 0; m_lut = '0;
            m_bits.delete();
        end else if (m_commit) begin
            m_commit = 0;
        end else if (s) begin
            m_active = 1; m_err = 0;
            m_bits.delete();
        end else if (m_active && v) begin
            m_bits.push_back(d);
            if (m_bits.size() == W + int'(PAR_EN)) begin
                m_active = 0;
                p = 0;
                foreach (m_bits[i]) p ^= int'(m_bits[i]);
                if (!PAR_EN || p == 0) begin
                    f = '0;
                    for (int i = 0; i < W; i++) f = {f[62:0], m_bits[i]};
                    m_lut    = f;
                    m_commit = 1;
                end else begin
                    m_err = 1;
                end
            end
        end
    endtask

    task automatic cycle(input logic r, input logic s, input logic v, input logic d);
        rst           = r;
        bus.cfg_start = s;
        bus.cfg_valid = v;
        bus.cfg_data  = d;
        @(posedge clk);
        model_step(r, s, v, d);
        #1;
        check("lut_cfg",   bus.lut_cfg,            m_lut);
        check("cfg_done",  64'(bus.cfg_done),      64'(m_commit));
        check("cfg_ready", 64'(bus.cfg_ready),     64'(m_active));
        check("cfg_busy",  64'(bus.cfg_busy),      64'(m_active | m_commit));
        check("cfg_err",   64'(bus.cfg_err),       64'(m_err));
    endtask

    // gap_mode: 0 back-to-back, 1 one idle cycle before every bit, 2 random idle cycles
    task automatic send_bit(input logic d, input int gap_mode);
        if (gap_mode == 1) begin
            cycle(1'b0, 1'b0, 1'b0, 1'($urandom));
        end else if (gap_mode == 2) begin
            while ($urandom_range(99, 0) < 40) cycle(1'b0, 1'b0, 1'b0, 1'($urandom));
        end
        cycle(1'b0, 1'b0, 1'b1, d);
    endtask

    task automatic send_frame(input logic [63:0] f, input int gap_mode, input bit bad_par, input bit tail_rand);
        logic [63:0] fv;
        fv = f;
        cycle(1'b0, 1'b1, 1'($urandom), 1'($urandom));
        for (int i = W - 1; i >= 0; i--) send_bit(fv[i], gap_mode);
        if (PAR_EN) send_bit((^fv) ^ bad_par, gap_mode);
        cycle(1'b0, tail_rand ? 1'($urandom) : 1'b0, 1'($urandom), 1'($urandom));
    endtask

    logic [63:0] rf;

    initial begin
        rst = 1'b1;
        bus.cfg_start = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_data  = 1'b0;
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check("rst_lut", bus.lut_cfg, 64'h0);

        // Valid bits with no start are ignored.
        repeat (10) cycle(1'b0, 1'b0, 1'b1, 1'b1);
        check("idle_lut",  bus.lut_cfg,         64'h0);
        check("idle_busy", 64'(bus.cfg_busy),   64'h0);

        send_frame(64'h0123_4567_89AB_CDEF, 0, 1'b0, 1'b0);
        check("frame_b2b", bus.lut_cfg,               64'h0123456789ABCDEF);
        check("lut0",      64'(bus.lut_cfg[15:0]),    64'hCDEF);

        send_frame(64'h0123_4567_89AB_CDEF, 1, 1'b0, 1'b0);
        check("frame_alt", bus.lut_cfg, 64'h0123456789ABCDEF);

        // Abort after 30 bits of ones, then a full frame.
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (30) send_bit(1'b1, 0);
        send_frame(64'hFFFF_0000_AAAA_5555, 0, 1'b0, 1'b0);
        check("abort", bus.lut_cfg, 64'hFFFF0000AAAA5555);

`ifdef LUT4_CFG_PARITY_EN
        send_frame(64'h1, 0, 1'b0, 1'b0);
        check("par_ok", bus.lut_cfg, 64'h1);
        send_frame(64'h3, 2, 1'b1, 1'b0);
        check("par_err",  64'(bus.cfg_err), 64'h1);
        check("par_keep", bus.lut_cfg,      64'h1);
`endif

        // Reset in the middle of a frame.
        send_frame(64'hDEAD_BEEF_0000_0001, 2, 1'b0, 1'b0);
        check("pre_rst", bus.lut_cfg, 64'hDEADBEEF00000001);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (40) send_bit(1'($urandom), 0);
        cycle(1'b1, 1'b0, 1'b1, 1'b1);
        check("rst_mid_lut",   bus.lut_cfg,          64'h0);
        check("rst_mid_ready", 64'(bus.cfg_ready),   64'h0);
        check("rst_mid_busy",  64'(bus.cfg_busy),    64'h0);

        for (int k = 0; k < 24; k++) begin
            rf = {$urandom, $urandom};
            if ($urandom_range(3, 0) == 0) begin
                cycle(1'b0, 1'b1, 1'b0, 1'b0);
                repeat ($urandom_range(W, 1)) send_bit(1'($urandom), 2);
            end
            send_frame(rf, $urandom_range(2, 0), PAR_EN && ($urandom_range(3, 0) == 0), 1'b1);
            repeat ($urandom_range(3, 0)) cycle(1'b0, 1'b0, 1'($urandom), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/lut4_cfg_loader.md
# lut4_cfg_loader

Serial configuration loader that sits directly upstream of the programmable LUT4 bank in the progobj test top-level. It accepts a bit-serial truth-table stream from the chip's dedicated inputs and assembles it in a shadow register. After a complete, optionally parity-checked frame, it commits the frame atomically to the active configuration bus that drives the LUT4 cells. The LUT bank therefore never sees a partially loaded configuration.

## Interface
Parameters:
- `NUM_LUTS`, default 4: number of LUT4 cells configured.
- `LUT_BITS`, default 16: truth-table bits per LUT. Fixed at 16; the parameter exists only for width derivation. Frame width W = NUM_LUTS*LUT_BITS.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset. The top-level drives it from `~rst_n`.
- `cfg_start`  in  1  single-cycle pulse that begins a new frame.
- `cfg_valid`  in  1  qualifies `cfg_data` on this cycle.
- `cfg_data`  in  1  serial configuration bit, MSB of the frame first.
- `cfg_ready`  out  1  high while the loader accepts bits.
- `cfg_busy`  out  1  high in any state other than IDLE.
- `cfg_done`  out  1  one-cycle pulse on commit.
- `cfg_err`  out  1  sticky parity error flag; cleared by `cfg_start` or `rst`.
- `lut_cfg`  out  W  active configuration. LUT k uses bits [16k+15:16k].

## Operation
- States: IDLE, SHIFT, PARITY (present only with the macro), COMMIT.
- IDLE:
  - `cfg_start` moves to SHIFT.
  - On that transition: bit counter cleared, running parity cleared, `cfg_err` cleared.
  - `cfg_valid` is ignored in IDLE.
- SHIFT:
  - `cfg_ready` = 1.
  - Each cycle with `cfg_valid`=1: `shadow <= {shadow[W-2:0], cfg_data}`, counter increments, parity ^= `cfg_data`.
  - After the W-th accepted bit: go to PARITY if the macro is defined, otherwise to COMMIT.
- PARITY:
  - `cfg_ready` = 1.
  - The next valid bit is the parity bit.
  - If running parity ^ bit == 0 (even parity over W+1 bits), go to COMMIT.
  - Otherwise set `cfg_err`, go to IDLE, and leave `lut_cfg` unchanged.
- COMMIT:
  - Lasts one cycle with `cfg_ready` = 0.
  - `lut_cfg <= shadow`, `cfg_done` = 1, then return to IDLE.
- Counter width is $clog2(W+1). It never wraps, because the state changes exactly at count W.
- `cfg_start` in SHIFT or PARITY aborts the current frame:
  - restart in SHIFT with counter and parity cleared;
  - `cfg_valid` on the same cycle is ignored;
  - `lut_cfg` is unchanged.
- `cfg_start` during COMMIT is ignored; the commit completes.
- The shadow register is never cleared. Only the W bits of a completed frame reach `lut_cfg`.

## Timing
- Reset values: state IDLE, `lut_cfg`=0, `cfg_ready`=0, `cfg_busy`=0, `cfg_done`=0, `cfg_err`=0.
- `rst` mid-frame discards the frame and zeroes `lut_cfg` on the next edge.
- `cfg_ready` and `cfg_busy` are registered state decodes:
  - `cfg_ready` rises on the cycle after `cfg_start` is sampled.
  - `cfg_busy` rises the same cycle as `cfg_ready`.
- Commit latency:
  - `lut_cfg` updates and `cfg_done` is high in the cycle after the last data bit (no macro) or after the parity bit (macro defined).
  - In both cases `lut_cfg` and `cfg_done` change on the same edge.
- `cfg_err` rises in the cycle after a bad parity bit and holds until `cfg_start` or `rst`.
- Bits may arrive back-to-back: one bit per cycle, maximum throughput.
- Gaps in `cfg_valid` are allowed, with no timeout.

## Configuration
- Macro: `LUT4_CFG_PARITY_EN`.
- Defined:
  - the PARITY state exists;
  - a frame is W+1 bits;
  - a parity mismatch sets `cfg_err` and suppresses the commit.
- Undefined:
  - no PARITY state;
  - a frame is W bits;
  - `cfg_err` is tied to 0.

## Test plan
- Reset then idle: `lut_cfg`==0 and all flags 0. 10 cycles of `cfg_valid`=1, `cfg_data`=1 with no `cfg_start` -> `lut_cfg` stays 0 and `cfg_busy`=0.
- Load 64'h0123_4567_89AB_CDEF MSB-first, no macro, `cfg_valid` continuous -> exactly one `cfg_done` pulse the cycle after bit 64. `lut_cfg`==64'h0123456789ABCDEF; LUT0 = 16'hCDEF.
- Same frame with `cfg_valid` toggled every other cycle -> identical `lut_cfg`; `cfg_done` one cycle after the last valid bit.
- Abort: 30 bits of 1s, then `cfg_start`, then a full frame 64'hFFFF_0000_AAAA_5555 -> `lut_cfg`==64'hFFFF0000AAAA5555. No `cfg_done` pulse before the final commit.
- With `LUT4_CFG_PARITY_EN`:
  - frame 64'h1 with parity bit 1 -> commit;
  - then frame 64'h3 with parity bit 1 -> `cfg_err`=1, no `cfg_done`, `lut_cfg` stays 64'h1.
- `rst` asserted after 40 bits of a frame, following an earlier commit of 64'hDEAD_BEEF_0000_0001 -> next cycle `lut_cfg`==0, state IDLE, `cfg_ready`=0.
